inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the program counter register. Each cycle it takes the current PC and chip-enable and runs a one-outstanding-request fetch on the instruction bus (SRAM-like addr_ok/data_ok handshake). It buffers the returned word and drives the IF/ID pipeline register that decode consumes. It raises a stall request while a fetch is incomplete, and drops in-flight data after a CP0 redirect.

Parameters:
NOP_INST, 32'h0000_0000, instruction word presented to ID for bubbles, flushes and faulting fetches

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pc_i  in  32  current PC from the PC register
ce_i  in  1  PC chip-enable; 0 = PC held in reset, no fetching
stall  in  6  pipeline stall vector; [0] PC, [1] IF/ID, [2] ID/EX
flush_i  in  1  CP0 redirect (exception/eret); kills the current fetch
inst_req  out  1  bus request valid
inst_addr  out  32  bus request address
inst_addr_ok  in  1  bus accepted the request this cycle
inst_rdata  in  32  bus read data
inst_data_ok  in  1  inst_rdata valid this cycle
stallreq_if  out  1  fetch not complete; the controller must hold stall[0] and stall[1]
id_pc  out  32  IF/ID register: PC of the instruction
id_inst  out  32  IF/ID register: instruction word
id_valid  out  1  IF/ID register: slot holds a real instruction
id_exc_adel  out  1  IF/ID register: fetch address error (pc[1:0] != 0)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; id_pc=0, id_inst=NOP_INST, id_valid=0, id_exc_adel=0; internal buffers cleared. Combinational outputs at reset: inst_req=0, stallreq_if=0.
- States: IDLE, REQ, WAIT, DISCARD, DONE.
- IDLE: no request. ce_i=1 -> REQ.
- REQ:
  - inst_req=1 and inst_addr=pc_i when pc_i[1:0]==0.
  - inst_addr_ok=1 -> WAIT, and pc_i is latched as fetch_pc.
  - pc_i[1:0]!=0: no bus request; buffer {pc_i, NOP_INST, adel=1} -> DONE next cycle.
- WAIT: inst_data_ok=1 -> buffer {fetch_pc, inst_rdata, adel=0} -> DONE.
- DONE:
  - The buffer is held.
  - When stall[1]=0, the IF/ID register loads the buffer with id_valid=1 and the state goes to REQ. The PC advances on the same edge.
- stallreq_if=1 in REQ, WAIT and DISCARD while ce_i=1; 0 in IDLE and DONE.
- The upstream PC only changes when stall[0]=0, so pc_i is stable throughout REQ and WAIT.
- At most one outstanding bus transaction at any time. inst_req is never asserted in WAIT or DISCARD.
- IF/ID register update rules, in priority order:
  1. rst=1: reset values.
  2. flush_i=1: bubble, i.e. id_inst=NOP_INST, id_valid=0, id_exc_adel=0, id_pc unchanged.
  3. stall[1]=1 and stall[2]=0: bubble.
  4. stall[1]=1 and stall[2]=1: hold.
  5. stall[1]=0 and state≠DONE: bubble.
  6. stall[1]=0 and state=DONE: load the buffer.
- Flush, for each state on a flush_i=1 cycle:
  - REQ with inst_addr_ok=1 on the same cycle -> DISCARD.
  - REQ otherwise -> REQ, reissued next cycle with the new pc_i.
  - WAIT with inst_data_ok=0 -> DISCARD.
  - WAIT with inst_data_ok=1 -> REQ; the returned data is dropped.
  - DONE -> REQ; the buffer is dropped.
  - IDLE -> IDLE.
- DISCARD: wait for inst_data_ok, drop the data, then -> REQ. A flush_i during DISCARD keeps the state DISCARD.
- ce_i falling to 0: from REQ -> IDLE. From WAIT -> DISCARD, then -> IDLE instead of REQ. From DONE -> IDLE.
- Reset mid-transaction: state returns to IDLE. Any later inst_data_ok is ignored in IDLE.
- Latency: with zero-wait memory (addr_ok in REQ, data_ok the next cycle), the word is in id_inst 3 cycles after REQ entry. Throughput is one instruction per 3 cycles.

Test Plan:
- Reset, then ce_i=1, pc_i=32'hBFC00000, addr_ok immediate, data_ok one cycle later with rdata=32'h3C08BFC0 -> inst_addr=BFC00000. Next the IF/ID register shows id_pc=BFC00000, id_inst=3C08BFC0, id_valid=1. stallreq_if is high only in REQ/WAIT.
- Slow bus: addr_ok delayed 3 cycles and data_ok delayed 2 more -> inst_req stays high with a stable address. Exactly one transaction is issued. id_valid stays 0 until load. stallreq_if=1 throughout.
- flush_i during WAIT, then data_ok=1 two cycles later with rdata=32'hDEADBEEF -> DEADBEEF never reaches id_inst. The next request uses the new pc_i (32'hBFC00380). id_valid=0 on the flush cycle.
- pc_i=32'hBFC00002 -> no inst_req. The IF/ID register shows id_exc_adel=1, id_inst=NOP_INST, id_valid=1, id_pc=BFC00002.
- DONE with stall=6'b000011 -> id_inst goes to a bubble and the buffer is held. With stall=6'b000111, the prior IF/ID contents are held. On release, the buffered word loads unchanged.
- rst asserted in WAIT, then data_ok arrives -> all outputs at reset values and the data is ignored. Fetching resumes from REQ after ce_i returns to 1.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and the instruction memory (slave).
//
// Handshake: the master holds inst_req=1 with a stable inst_addr until the
// slave answers inst_addr_ok=1 in the same cycle; that cycle is the accept.
// Afterwards the slave returns exactly one word by pulsing inst_data_ok=1
// with inst_rdata valid in that cycle. The master never has more than one
// accepted request without its data.
interface inst_fetch_unit_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_rdata,
        input  inst_data_ok
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_rdata,
        output inst_data_ok
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: one-outstanding-request fetch FSM, a one-entry
// result buffer and the IF/ID pipeline register feeding decode.
module inst_fetch_unit #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_i,
    input  logic                      ce_i,
    input  logic [5:0]                stall,
    input  logic                      flush_i,
    inst_fetch_unit_if.master         bus,
    output logic                      stallreq_if,
    output logic [31:0]               id_pc,
    output logic [31:0]               id_inst,
    output logic                      id_valid,
    output logic                      id_exc_adel,
    output logic [2:0]                dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_DISCARD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        buf_adel_q, buf_adel_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        id_adel_q, id_adel_d;
    logic        pc_aligned;

    // Only the IF/ID stall bits (1 and 2) matter here; the rest belong to other stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:3], stall[0]};

    assign pc_aligned = (pc_i[1:0] == 2'b00);

    // Fetch FSM next state, bus request and result buffer capture.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        buf_pc_d      = buf_pc_q;
        buf_inst_d    = buf_inst_q;
        buf_adel_d    = buf_adel_q;
        bus.inst_req  = 1'b0;
        bus.inst_addr = 32'h0000_0000;

        case (state_q)
            S_IDLE: begin
                if (ce_i && !flush_i) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!ce_i) begin
                    state_d = S_IDLE;
                end else if (!pc_aligned) begin
                    // Misaligned PC never reaches the bus; it becomes a faulting NOP.
                    if (!flush_i) begin
                        buf_pc_d   = pc_i;
                        buf_inst_d = NOP_INST;
                        buf_adel_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end else begin
                    bus.inst_req  = 1'b1;
                    bus.inst_addr = pc_i;
                    if (bus.inst_addr_ok) begin
                        fetch_pc_d = pc_i;
                        // An accepted request cannot be cancelled, so its data must be drained.
                        state_d    = flush_i ? S_DISCARD : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (flush_i || !ce_i) begin
                        state_d = ce_i ? S_REQ : S_IDLE;
                    end else begin
                        buf_pc_d   = fetch_pc_q;
                        buf_inst_d = bus.inst_rdata;
                        buf_adel_d = 1'b0;
                        state_d    = S_DONE;
                    end
                end else if (flush_i || !ce_i) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (bus.inst_data_ok) begin
                    state_d = ce_i ? S_REQ : S_IDLE;
                end
            end
            S_DONE: begin
                if (!ce_i) begin
                    state_d = S_IDLE;
                end else if (flush_i || !stall[1]) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall request while a fetch is still in progress.
    always_comb begin
        stallreq_if = ce_i && ((state_q == S_REQ) || (state_q == S_WAIT) ||
                               (state_q == S_DISCARD));
    end

    // IF/ID register next value: flush, then stall bubble/hold, then load or bubble.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_adel_d  = id_adel_q;

        if (flush_i || (stall[1] && !stall[2]) || (!stall[1] && (state_q != S_DONE))) begin
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
        end else if (!stall[1]) begin
            id_pc_d    = buf_pc_q;
            id_inst_d  = buf_inst_q;
            id_valid_d = 1'b1;
            id_adel_d  = buf_adel_q;
        end
    end

    // State, buffer and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= 32'h0000_0000;
            buf_pc_q   <= 32'h0000_0000;
            buf_inst_q <= NOP_INST;
            buf_adel_q <= 1'b0;
            id_pc_q    <= 32'h0000_0000;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_adel_q <= buf_adel_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_adel_q  <= id_adel_d;
        end
    end

    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_valid    = id_valid_q;
    assign id_exc_adel = id_adel_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: scripted bus responses, a scoreboard of
// expected IF/ID loads popped by an independent monitor, and direct checks of
// the bus request and stall request outputs.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [5:0]  stall;
    logic        flush_i;
    logic        stallreq_if;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_exc_adel;
    logic [2:0]  dbg_state;

    inst_fetch_unit_if bus();

    inst_fetch_unit #(.NOP_INST(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ce_i        (ce_i),
        .stall       (stall),
        .flush_i     (flush_i),
        .bus         (bus),
        .stallreq_if (stallreq_if),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .id_exc_adel (id_exc_adel),
        .dbg_state_o (dbg_state)
    );

    int tests;
    int failed;
    int hs_cnt;
    int exp_hs;
    logic last_load_ok;
    logic [64:0] exp_q[$];

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        exp_q.push_back({pc, inst, adel});
    endtask

    // Bus handshake counter and record of whether this edge may load IF/ID
    always @(posedge clk) begin
        if (bus.inst_req && bus.inst_addr_ok) hs_cnt <= hs_cnt + 1;
        last_load_ok <= !stall[1] && !flush_i && !rst;
    end

    // Monitor: a freshly loaded IF/ID slot must match the scoreboard head
    always @(negedge clk) begin
        logic [64:0] e;
        if (id_valid && last_load_ok) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL sb_unexpected: got pc %h inst %h expected no load", id_pc, id_inst);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", id_pc, e[64:33]);
                chk("sb_inst", id_inst, e[32:1]);
                chk("sb_adel", {31'b0, id_exc_adel}, {31'b0, e[0]});
            end
        end
    end

    initial begin
        tests = 0; failed = 0; hs_cnt = 0; exp_hs = 0;
        rst = 1'b1; ce_i = 1'b0; pc_i = 32'h0; stall = 6'b0; flush_i = 1'b0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;

        // Reset state
        step(); step();
        settle();
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_id_adel", {31'b0, id_exc_adel}, 32'h0);
        chk("rst_req", {31'b0, bus.inst_req}, 32'h0);
        chk("rst_stallreq", {31'b0, stallreq_if}, 32'h0);

        // T1: zero-wait fetch at the boot vector
        step(); rst = 1'b0; ce_i = 1'b1; pc_i = 32'hBFC0_0000;
        settle();
        chk("t1_idle_req", {31'b0, bus.inst_req}, 32'h0);
        chk("t1_idle_stallreq", {31'b0, stallreq_if}, 32'h0);
        step(); bus.inst_addr_ok = 1'b1;
        settle();
        chk("t1_req", {31'b0, bus.inst_req}, 32'h1);
        chk("t1_addr", bus.inst_addr, 32'hBFC0_0000);
        chk("t1_req_stallreq", {31'b0, stallreq_if}, 32'h1);
        push_exp(32'hBFC0_0000, 32'h3C08_BFC0, 1'b0); exp_hs++;
        step(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3C08_BFC0;
        settle();
        chk("t1_wait_req", {31'b0, bus.inst_req}, 32'h0);
        chk("t1_wait_stallreq", {31'b0, stallreq_if}, 32'h1);
        step(); bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'hFFFF_FFFF;
        settle();
        chk("t1_done_stallreq", {31'b0, stallreq_if}, 32'h0);
        chk("t1_done_req", {31'b0, bus.inst_req}, 32'h0);
        chk("t1_done_id_valid", {31'b0, id_valid}, 32'h0);
        step(); pc_i = 32'hBFC0_0004;
        settle();
        chk("t1_load_inst", id_inst, 32'h3C08_BFC0);
        chk("t1_load_valid", {31'b0, id_valid}, 32'h1);

        // T2: slow bus, addr_ok after 3 cycles, data_ok 2 cycles later
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin step(); settle(); end
            chk("t2_req_held", {31'b0, bus.inst_req}, 32'h1);
            chk("t2_addr_stable", bus.inst_addr, 32'hBFC0_0004);
            chk("t2_stallreq", {31'b0, stallreq_if}, 32'h1);
            if (i > 0) chk("t2_id_bubble", {31'b0, id_valid}, 32'h0);
        end
        step(); bus.inst_addr_ok = 1'b1;
        settle();
        chk("t2_req_accept", {31'b0, bus.inst_req}, 32'h1);
        push_exp(32'hBFC0_0004, 32'h2408_0001, 1'b0); exp_hs++;
        step(); bus.inst_addr_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t2_wait_noreq", {31'b0, bus.inst_req}, 32'h0);
            chk("t2_wait_stallreq", {31'b0, stallreq_if}, 32'h1);
            chk("t2_wait_id_valid", {31'b0, id_valid}, 32'h0);
            step();
        end
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h2408_0001;
        step(); bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h1234_5678;
        settle();
        chk("t2_done_stallreq", {31'b0, stallreq_if}, 32'h0);
        step(); pc_i = 32'hBFC0_0008;

        // T3: flush while waiting for data; returned word must be dropped
        bus.inst_addr_ok = 1'b1;
        settle();
        chk("t3_addr", bus.inst_addr, 32'hBFC0_0008);
        exp_hs++;
        step(); bus.inst_addr_ok = 1'b0; flush_i = 1'b1; pc_i = 32'hBFC0_0380;
        settle();
        chk("t3_flush_noreq", {31'b0, bus.inst_req}, 32'h0);
        step(); flush_i = 1'b0;
        settle();
        chk("t3_flush_bubble", {31'b0, id_valid}, 32'h0);
        chk("t3_discard_noreq", {31'b0, bus.inst_req}, 32'h0);
        chk("t3_discard_stallreq", {31'b0, stallreq_if}, 32'h1);
        step(); bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t3_discard_noreq2", {31'b0, bus.inst_req}, 32'h0);
        step(); bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0; bus.inst_addr_ok = 1'b1;
        settle();
        chk("t3_reissue_req", {31'b0, bus.inst_req}, 32'h1);
        chk("t3_reissue_addr", bus.inst_addr, 32'hBFC0_0380);
        push_exp(32'hBFC0_0380, 32'h4082_6000, 1'b0); exp_hs++;
        step(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h4082_6000;
        step(); bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'hDEAD_BEEF;
        step(); pc_i = 32'hBFC0_0002;

        // T4: misaligned PC, no bus request, faulting NOP
        settle();
        chk("t3_load_inst", id_inst, 32'h4082_6000);
        chk("t4_noreq", {31'b0, bus.inst_req}, 32'h0);
        chk("t4_stallreq", {31'b0, stallreq_if}, 32'h1);
        push_exp(32'hBFC0_0002, 32'h0000_0000, 1'b1);
        step();
        settle();
        chk("t4_done_noreq", {31'b0, bus.inst_req}, 32'h0);
        chk("t4_done_stallreq", {31'b0, stallreq_if}, 32'h0);

        // T5: stall hold / bubble / hold, then release loads the buffer
        step(); pc_i = 32'hBFC0_0010; stall = 6'b000111; bus.inst_addr_ok = 1'b1;
        settle();
        chk("t4_adel", {31'b0, id_exc_adel}, 32'h1);
        chk("t4_valid", {31'b0, id_valid}, 32'h1);
        chk("t4_pc", id_pc, 32'hBFC0_0002);
        chk("t4_inst", id_inst, 32'h0);
        chk("t5_req", {31'b0, bus.inst_req}, 32'h1);
        push_exp(32'hBFC0_0010, 32'h8D09_0000, 1'b0); exp_hs++;
        step(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h8D09_0000;
        settle();
        chk("t5_hold_valid", {31'b0, id_valid}, 32'h1);
        chk("t5_hold_pc", id_pc, 32'hBFC0_0002);
        step(); bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h5555_AAAA;
        settle();
        chk("t5_done_hold_valid", {31'b0, id_valid}, 32'h1);
        chk("t5_done_stallreq", {31'b0, stallreq_if}, 32'h0);
        step(); stall = 6'b000011;
        settle();
        chk("t5_hold_adel", {31'b0, id_exc_adel}, 32'h1);
        step();
        settle();
        chk("t5_bubble_valid", {31'b0, id_valid}, 32'h0);
        chk("t5_bubble_inst", id_inst, 32'h0);
        chk("t5_bubble_adel", {31'b0, id_exc_adel}, 32'h0);
        chk("t5_bubble_pc", id_pc, 32'hBFC0_0002);
        step(); stall = 6'b000111;
        settle();
        chk("t5_hold_bubble", {31'b0, id_valid}, 32'h0);
        step(); stall = 6'b000000;
        settle();
        chk("t5_still_done_noreq", {31'b0, bus.inst_req}, 32'h0);
        step(); pc_i = 32'hBFC0_0014;

        // T6: reset while waiting; late data_ok ignored; restart after ce_i
        bus.inst_addr_ok = 1'b1;
        settle();
        chk("t5_load_inst", id_inst, 32'h8D09_0000);
        chk("t6_req", {31'b0, bus.inst_req}, 32'h1);
        exp_hs++;
        step(); bus.inst_addr_ok = 1'b0; rst = 1'b1;
        settle();
        chk("t6_wait_stallreq", {31'b0, stallreq_if}, 32'h1);
        step(); rst = 1'b0; ce_i = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hCAFE_BABE;
        settle();
        chk("t6_rst_id_pc", id_pc, 32'h0);
        chk("t6_rst_id_inst", id_inst, 32'h0);
        chk("t6_rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("t6_rst_id_adel", {31'b0, id_exc_adel}, 32'h0);
        chk("t6_rst_req", {31'b0, bus.inst_req}, 32'h0);
        chk("t6_rst_stallreq", {31'b0, stallreq_if}, 32'h0);
        step(); bus.inst_data_ok = 1'b0; ce_i = 1'b1;
        settle();
        chk("t6_idle_noreq", {31'b0, bus.inst_req}, 32'h0);
        chk("t6_idle_id_valid", {31'b0, id_valid}, 32'h0);
        step(); bus.inst_addr_ok = 1'b1;
        settle();
        chk("t6_resume_req", {31'b0, bus.inst_req}, 32'h1);
        chk("t6_resume_addr", bus.inst_addr, 32'hBFC0_0014);
        push_exp(32'hBFC0_0014, 32'h1111_1111, 1'b0); exp_hs++;
        step(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1111_1111;
        step(); bus.inst_data_ok = 1'b0;
        step(); ce_i = 1'b0;
        settle();
        chk("t6_load_inst", id_inst, 32'h1111_1111);
        step(); step();
        settle();
        chk("end_idle_noreq", {31'b0, bus.inst_req}, 32'h0);
        chk("end_sb_empty", exp_q.size(), 32'h0);
        chk("end_handshakes", hs_cnt, exp_hs);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
